// File: rtl/xbar_pkg.sv
// Shared crossbar types: B-channel FSM state encoding and BRESP codes.
package xbar_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from last_grant+1 with wrap-around;
// the pointer advances only when an enabled arbitration finds a requester.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [$clog2(N)-1:0] o_winner,
  output logic                 o_valid
);

  localparam int W = $clog2(N);

  logic [W-1:0] r_last;
  int           w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = W'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= W'(N - 1);
    end else if (i_en && o_valid) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/b_resp_arbiter.sv
// Merges NUM_SRC AXI B channels into one registered output with round-robin.
// Optional SLVERR/DECERR counter enabled by macro B_RESP_ARBITER_ERR_CNT_EN.
//
// state   | meaning
// IDLE    | output register empty, arbitrate every cycle
// SEND    | output register full, arbitrate only when M_BREADY=1
module b_resp_arbiter
  import xbar_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int NUM_SRC  = 2
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_SRC-1:0]          S_BVALID,
  input  logic [NUM_SRC*ID_WIDTH-1:0] S_BID,
  input  logic [NUM_SRC*2-1:0]        S_BRESP,
  output logic [NUM_SRC-1:0]          S_BREADY,
  output logic                        M_BVALID,
  output logic [ID_WIDTH-1:0]         M_BID,
  output logic [1:0]                  M_BRESP,
  input  logic                        M_BREADY,
`ifdef B_RESP_ARBITER_ERR_CNT_EN
  output logic [7:0]                  err_count,
`endif
  output logic [$clog2(NUM_SRC)-1:0]  grant_src
);

  localparam int W = $clog2(NUM_SRC);

  state_e                r_state;
  state_e                w_next_state;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic [W-1:0]          r_grant_src;
  logic [W-1:0]          w_winner;
  logic                  w_valid;
  logic                  w_en;
  logic                  w_grant;

  // Reset masks arbitration so no source sees ready in the reset cycle.
  assign w_en = ((r_state == ST_IDLE) || M_BREADY) && !ARESET;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk      (ACLK),
    .rst      (ARESET),
    .i_req    (S_BVALID),
    .i_en     (w_en),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    S_BREADY     = '0;
    w_grant      = 1'b0;
    if (w_en) begin
      if (w_valid) begin
        w_next_state       = ST_SEND;
        S_BREADY[w_winner] = 1'b1;
        w_grant            = 1'b1;
      end else begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_bid       <= '0;
      r_bresp     <= BRESP_OKAY;
      r_grant_src <= '0;
    end else if (w_grant) begin
      r_bid       <= S_BID[int'(w_winner)*ID_WIDTH +: ID_WIDTH];
      r_bresp     <= S_BRESP[int'(w_winner)*2 +: 2];
      r_grant_src <= w_winner;
    end
  end

  assign M_BVALID  = (r_state == ST_SEND);
  assign M_BID     = r_bid;
  assign M_BRESP   = r_bresp;
  assign grant_src = r_grant_src;

`ifdef B_RESP_ARBITER_ERR_CNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_err_count <= '0;
    end else if (M_BVALID && M_BREADY && r_bresp[1] && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
